// File: rtl/clk_div_n.sv
// Programmable 50%-duty integer clock divider with glitch-free divisor change, start and stop.
// Define CLK_DIV_ODD_EN to accept odd divisors (adds a negedge phase flop).
module clk_div_n #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] div_val,
  output logic             clock_out,
  output logic             running,
  output logic             pending,
  output logic             period_tick,
  output logic             cfg_err
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pend_q, pend_d;
  logic             pos_q, pos_d;
  logic             cfg_err_q, cfg_err_d;
  logic             load_ok_s;
  logic             wrap_s;
  logic             apply_s;
  logic [WIDTH:0]   half_s;

`ifdef CLK_DIV_ODD_EN
  assign load_ok_s = (div_val >= WIDTH'(2));
`else
  assign load_ok_s = (div_val >= WIDTH'(2)) && !div_val[0];
`endif

  assign wrap_s      = (state_q == ST_RUN) && (cnt_q == (div_q - WIDTH'(1)));
  // High-phase length: N/2 for even N, (N+1)/2 for odd N
  assign half_s      = ({1'b0, div_q} + (WIDTH+1)'(1)) >> 1;
  assign period_tick = wrap_s;
  assign running     = (state_q == ST_RUN);
  assign pending     = pend_q;
  assign cfg_err     = cfg_err_q;

  // State, counter, phase flop and divisor registers
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pos_q      <= 1'b0;
      div_q      <= DEF_DIV;
      pend_div_q <= DEF_DIV;
      pend_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pos_q      <= pos_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pend_q     <= pend_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // Next-state: divisor changes only at IDLE->RUN or at a period wrap
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pos_d      = pos_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    apply_s    = 1'b0;
    cfg_err_d  = load & ~load_ok_s;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d = ST_RUN;
          pos_d   = 1'b1;
          apply_s = pend_q;
        end else begin
          pos_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (wrap_s) begin
          cnt_d   = '0;
          apply_s = pend_q;
          if (enable) begin
            pos_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            pos_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
          pos_d = ({1'b0, cnt_d} < half_s);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        pos_d   = 1'b0;
      end
    endcase
    if (apply_s) begin
      div_d  = pend_div_q;
      pend_d = 1'b0;
    end else begin
      div_d = div_q;
    end
    // A load on the wrap edge re-arms pending after the older value is applied
    if (load && load_ok_s) begin
      pend_div_d = div_val;
      pend_d     = 1'b1;
    end else begin
      pend_div_d = pend_div_q;
    end
  end

`ifdef CLK_DIV_ODD_EN
  logic neg_q;

  // Half-cycle delayed copy of the phase flop for odd divisors
  always_ff @(negedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q;
    end
  end

  assign clock_out = div_q[0] ? (pos_q & neg_q) : pos_q;
`else
  assign clock_out = pos_q;
`endif

endmodule
